// File: rtl/bus_transfer_sequencer.sv
// bus_transfer_sequencer: drives OE_n/LE of the bus registers to copy one register into another
// over the shared bus: drive source, settle, pulse destination LE, hold source, release.
module bus_transfer_sequencer #(
    parameter int NUM_REGS      = 4,
    parameter int SEL_W         = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int LATCH_CYCLES  = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SEL_W-1:0]    req_src,
    input  logic [SEL_W-1:0]    req_dst,
    output logic [NUM_REGS-1:0] oe_n,
    output logic [NUM_REGS-1:0] le,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] LATCH = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;
    localparam int MAXC = (SETTLE_CYCLES > LATCH_CYCLES) ? SETTLE_CYCLES : LATCH_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] LATCH_LD  = CW'(LATCH_CYCLES - 1);
    localparam logic [SEL_W:0] NR = (SEL_W + 1)'(NUM_REGS);

    logic [1:0]          state, state_nx;
    logic [CW-1:0]       cnt, cnt_nx;
    logic [SEL_W-1:0]    src, dst, src_nx, dst_nx;
    logic [NUM_REGS-1:0] src_mask, dst_mask;
    logic                accept, bad;

    assign accept   = req_valid && state == IDLE;
    assign bad      = req_src == req_dst || {1'b0, req_src} >= NR || {1'b0, req_dst} >= NR;
    assign src_mask = NUM_REGS'(1) << src_nx;
    assign dst_mask = NUM_REGS'(1) << dst_nx;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        src_nx   = src;
        dst_nx   = dst;
        case (state)
            IDLE: if (accept && !bad) begin
                state_nx = DRIVE;
                cnt_nx   = SETTLE_LD;
                src_nx   = req_src;
                dst_nx   = req_dst;
            end
            DRIVE: if (cnt == '0) begin
                state_nx = LATCH;
                cnt_nx   = LATCH_LD;
            end else begin
                cnt_nx = cnt - 1'b1;
            end
            LATCH: if (cnt == '0) state_nx = HOLD;
                   else cnt_nx = cnt - 1'b1;
            default: state_nx = IDLE;
        endcase
    end

    // outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            src       <= '0;
            dst       <= '0;
            oe_n      <= '1;
            le        <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            src       <= src_nx;
            dst       <= dst_nx;
            oe_n      <= (state_nx == IDLE) ? '1 : ~src_mask;
            le        <= (state_nx == LATCH) ? dst_mask : '0;
            req_ready <= state_nx == IDLE;
            busy      <= state_nx != IDLE;
            done      <= state == HOLD;
            err       <= accept && bad;
        end
    end
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// tb_bus_transfer_sequencer: directed and randomised checks of the bus transfer sequencer,
// with expected events queued at stimulus time and checked by independent monitors.
module tb_bus_transfer_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n = 1'b0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0, miscompares = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Instance A: default timing, 3-bit selects so out-of-range indices can be requested
    logic       a_valid = 1'b0, a_ready, a_busy, a_done, a_err;
    logic [2:0] a_src = '0, a_dst = '0;
    logic [3:0] a_oe, a_le;
    bus_transfer_sequencer #(.NUM_REGS(4), .SEL_W(3), .SETTLE_CYCLES(2), .LATCH_CYCLES(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .req_valid(a_valid), .req_ready(a_ready),
        .req_src(a_src), .req_dst(a_dst), .oe_n(a_oe), .le(a_le),
        .busy(a_busy), .done(a_done), .err(a_err));

    // Instance B: longer settle/latch for the randomised run
    logic       b_valid = 1'b0, b_ready, b_busy, b_done, b_err;
    logic [1:0] b_src = '0, b_dst = '0;
    logic [3:0] b_oe, b_le;
    bus_transfer_sequencer #(.NUM_REGS(4), .SEL_W(2), .SETTLE_CYCLES(3), .LATCH_CYCLES(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .req_valid(b_valid), .req_ready(b_ready),
        .req_src(b_src), .req_dst(b_dst), .oe_n(b_oe), .le(b_le),
        .busy(b_busy), .done(b_done), .err(b_err));

    typedef struct {
        int cyc;
        logic [3:0] oe;
        logic [3:0] le;
        logic ready;
        logic done;
        logic err;
    } exp_a_t;
    exp_a_t exp_a[$];

    task automatic push_a(int c, logic [3:0] oe, logic [3:0] le, logic r, logic d, logic e);
        exp_a_t t;
        t.cyc = c; t.oe = oe; t.le = le; t.ready = r; t.done = d; t.err = e;
        exp_a.push_back(t);
    endtask

    task automatic xfer_a(int a, logic [3:0] oe, logic [3:0] le);
        push_a(a,     oe,      4'b0000, 1'b0, 1'b0, 1'b0);
        push_a(a + 1, oe,      4'b0000, 1'b0, 1'b0, 1'b0);
        push_a(a + 2, oe,      le,      1'b0, 1'b0, 1'b0);
        push_a(a + 3, oe,      4'b0000, 1'b0, 1'b0, 1'b0);
        push_a(a + 4, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_a_t t;
        while (exp_a.size() > 0 && exp_a[0].cyc < cyc) begin
            t = exp_a.pop_front();
            check("a_expectation_skipped", 32'(t.cyc), 32'(cyc));
        end
        if (exp_a.size() > 0 && exp_a[0].cyc == cyc) begin
            t = exp_a.pop_front();
            check("a_oe_n", a_oe, t.oe);
            check("a_le", a_le, t.le);
            check("a_ready", a_ready, t.ready);
            check("a_busy", a_busy, !t.ready);
            check("a_done", a_done, t.done);
            check("a_err", a_err, t.err);
        end else if (a_done || a_err) begin
            check("a_spurious_pulse", {a_done, a_err}, 0);
        end
    end

    typedef struct {
        logic is_err;
        int dst;
        logic [31:0] val;
    } exp_b_t;
    exp_b_t exp_b[$];
    logic [31:0] model[4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
    logic [31:0] phys[4]  = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
    logic        inj_en = 1'b0;
    int          inj_idx = 0;
    logic [31:0] inj_val = '0;
    int          done_cnt = 0, accepts = 0, issued = 0;

    // physical bus registers: transparent latches fed from whichever register drives the bus
    always @(negedge clk) begin
        exp_b_t t;
        if (reset_n) begin
            check("b_inv_one_oe", $countones(~b_oe) <= 1, 1);
            check("b_inv_one_le", $countones(b_le) <= 1, 1);
            check("b_inv_le_src", b_le == 4'b0 || ((~b_oe) != 4'b0 && (b_le & ~b_oe) == 4'b0), 1);
            check("b_busy_ready", b_busy, !b_ready);
        end
        if (inj_en) phys[inj_idx] = inj_val;
        for (int d = 0; d < 4; d++)
            if (b_le[d])
                for (int s = 0; s < 4; s++)
                    if (!b_oe[s]) phys[d] = phys[s];
        if (b_done || b_err) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected_pulse", {b_done, b_err}, 0);
            end else begin
                t = exp_b.pop_front();
                check("b_kind", b_err, t.is_err);
                if (b_done) begin
                    done_cnt++;
                    check("b_latched", phys[t.dst], t.val);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, budget, s, d;
        // reset held with a pending request
        a_valid = 1'b1; a_src = 3'd0; a_dst = 3'd1;
        repeat (3) begin
            @(negedge clk);
            check("rst_oe_n", a_oe, 4'b1111);
            check("rst_le", a_le, 4'b0000);
            check("rst_ready", a_ready, 1'b1);
            check("rst_done_err", {a_done, a_err}, 0);
        end
        a_valid = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        // 0 -> 2
        a_src = 3'd0; a_dst = 3'd2; a_valid = 1'b1;
        xfer_a(cyc + 1, 4'b1110, 4'b0100);
        @(negedge clk) a_valid = 1'b0;
        repeat (6) @(negedge clk);
        // rejects: src == dst, then dst out of range
        a_src = 3'd1; a_dst = 3'd1; a_valid = 1'b1;
        push_a(cyc + 1, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        a_src = 3'd0; a_dst = 3'd5;
        push_a(cyc + 1, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        a_valid = 1'b0;
        push_a(cyc + 1, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        // 3 -> 0 held valid throughout, then 0 -> 3 presented in the done cycle
        a_src = 3'd3; a_dst = 3'd0; a_valid = 1'b1;
        a = cyc + 1;
        xfer_a(a, 4'b0111, 4'b0001);
        repeat (5) @(negedge clk);
        a_src = 3'd0; a_dst = 3'd3;
        xfer_a(cyc + 1, 4'b1110, 4'b1000);
        @(negedge clk) a_valid = 1'b0;
        repeat (6) @(negedge clk);
        // reset during LATCH
        a_src = 3'd1; a_dst = 3'd2; a_valid = 1'b1;
        a = cyc + 1;
        push_a(a,     4'b1101, 4'b0000, 1'b0, 1'b0, 1'b0);
        push_a(a + 1, 4'b1101, 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk) a_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("latch_le_before_reset", a_le, 4'b0100);
        #2 reset_n = 1'b0;
        #1;
        check("mid_reset_le", a_le, 4'b0000);
        check("mid_reset_oe_n", a_oe, 4'b1111);
        @(negedge clk) reset_n = 1'b1;
        repeat (8) @(negedge clk);
        // randomised run on instance B
        budget = 0;
        while (issued < 200 && budget < 6000) begin
            @(negedge clk);
            #1;
            budget++;
            b_valid = 1'b0;
            inj_en = 1'b0;
            if (b_ready && $urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    inj_idx = $urandom_range(0, 3);
                    inj_val = $urandom;
                    inj_en = 1'b1;
                    model[inj_idx] = inj_val;
                end else begin
                    exp_b_t t;
                    s = $urandom_range(0, 3);
                    d = $urandom_range(0, 3);
                    b_src = 2'(s); b_dst = 2'(d); b_valid = 1'b1;
                    t.is_err = (s == d); t.dst = d; t.val = model[s];
                    exp_b.push_back(t);
                    if (s != d) begin
                        model[d] = model[s];
                        accepts++;
                    end
                    issued++;
                end
            end
        end
        @(negedge clk);
        #1;
        b_valid = 1'b0;
        inj_en = 1'b0;
        repeat (20) @(negedge clk);
        check("b_issued", issued, 200);
        check("b_done_count", done_cnt, accepts);
        check("a_queue_drained", exp_a.size(), 0);
        check("b_queue_drained", exp_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
